mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter LINE_BYTES, default 16, meaning bytes per icache line (power of two, 4..64).
REQ-002 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port rdy, input, 1, global ready; when low, all state and outputs hold.
REQ-005 SHALL have port rb, input, 1, pipeline rollback pulse.
REQ-006 SHALL have ports fc_valid (input, 1), fc_addr (input, 32), fc_done (output, 1), fc_line (output, 8*LINE_BYTES): icache line-fetch channel.
REQ-007 SHALL have ports ld_valid (input, 1), ld_addr (input, 32), ld_len (input, 3), ld_done (output, 1), ld_data (output, 32): SLB load channel.
REQ-008 SHALL have ports st_valid (input, 1), st_addr (input, 32), st_data (input, 32), st_len (input, 3), st_done (output, 1): ROB committed-store channel.
REQ-009 SHALL have port io_buffer_full, input, 1, UART buffer full.
REQ-010 SHALL have ports ram_wr (output, 1, 1=write), ram_addr (output, 32), ram_dout (output, 8) and ram_din (input, 8): byte-wide RAM port.

Function
REQ-011 SHALL implement an FSM with states IDLE, FETCH, LOAD, STORE; exactly one transfer is active at a time.
REQ-012 In IDLE, a request SHALL be granted by fixed priority st > ld > fc; the grant and the first RAM access issue in the same cycle as the state change.
REQ-013 A requester SHALL hold valid and its address, length and data stable until its done pulse; the block latches them at grant.
REQ-014 Byte k SHALL be accessed at address base+k, little-endian, for k = 0..len-1; len is 1, 2 or 4 for ld/st and LINE_BYTES for fc.
REQ-015 Reads: the byte addressed in cycle t SHALL be captured from ram_din in cycle t+1; a len-N read therefore takes N+1 cycles from grant to done.
REQ-016 Writes: one byte SHALL be written per cycle with ram_wr=1; a len-N store takes N cycles, and st_done pulses in the cycle after the last byte.
REQ-017 ld_data SHALL be zero-extended; sign-extension is the SLB's responsibility.
REQ-018 fc_done, ld_done and st_done SHALL each pulse for exactly one cycle; fc_line and ld_data stay valid during the pulse and hold afterwards until the next completion.
REQ-019 After a done pulse the FSM SHALL return to IDLE; back-to-back grants SHALL therefore have at most one idle cycle between them.
REQ-020 An IO write (st_addr[17:16]==2'b11) SHALL NOT drive ram_wr while io_buffer_full=1; it waits, byte index unchanged.
REQ-021 When no write is active, ram_wr SHALL be 0 and ram_addr SHALL be 0 in IDLE.
REQ-022 On rb=1, an active FETCH or LOAD SHALL be aborted with no done pulse and the FSM SHALL go to IDLE next cycle; any ld/fc valid sampled in that cycle SHALL be ignored.
REQ-023 On rb=1, an active STORE SHALL continue to completion, because it is already committed; a pending st_valid remains eligible for grant.
REQ-024 When rb and a done pulse coincide for LOAD or FETCH, the done pulse SHALL be suppressed.
REQ-025 With rdy=0 mid-transfer, the byte counter, RAM outputs and FSM SHALL freeze; the read-capture pipeline SHALL resume correctly when rdy returns.

Reset
REQ-026 On rst, the FSM SHALL go to IDLE; all done outputs, ram_wr, ram_addr, ram_dout, ld_data and fc_line SHALL be 0; the byte counter SHALL be 0.
REQ-027 A reset asserted mid-transfer SHALL abandon the transfer with no done pulse.

Structure
REQ-028 FSM state encodings, the IO address-decode constant (2'b11 at [17:16]), ADDR/WORD widths and the LINE type SHALL live in the shared definitions header.
REQ-029 The block SHALL be a single module; an optional sub-module mem_byte_seq (address/counter/shift-capture engine) MAY be factored out and SHALL be shared by all three channels.

Verification
REQ-030 Load: ld lw at 0x100 with RAM bytes 11 22 33 44 -> reads at 0x100..0x103, ld_done 5 cycles after grant, ld_data=0x44332211.
REQ-031 Store: st_len=2, st_addr=0x200, st_data=0xABCD -> ram_wr=1 for 2 cycles, writing CD@0x200 then AB@0x201, followed by an st_done pulse.
REQ-032 Simultaneous st, ld and fc requests in IDLE -> served in the order st, ld, fc, each with exactly one done pulse.
REQ-033 Rollback during byte 7 of a 16-byte fetch -> no fc_done, IDLE next cycle, a subsequent ld is granted normally; rollback during a store -> the store completes with st_done.
REQ-034 IO store of 0x41 to 0x30000 with io_buffer_full high for 3 cycles -> ram_wr stays 0 for those cycles, the byte is written once the flag drops, then st_done.
REQ-035 rdy=0 for 2 cycles in the middle of a load, and rst asserted mid-fetch -> the load result is identical to the no-stall case; after rst all outputs are 0 and the state is IDLE.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_pkg
// Brief    : Shared types and constants for the byte-wide memory arbiter.
// Revision : 1.0
// ============================================================================
package mem_arbiter_pkg;

    localparam int c_addr_w         = 32;
    localparam int c_word_w         = 32;
    localparam int c_line_bytes_def = 16;

    // Address window [17:16] == 2'b11 maps onto the UART.
    localparam int         c_io_hi  = 17;
    localparam int         c_io_lo  = 16;
    localparam logic [1:0] c_io_sel = 2'b11;

    typedef logic [8*c_line_bytes_def-1:0] line_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_LOAD  = 2'd2,
        S_STORE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Brief    : Requester channels, control and byte-wide RAM bus of the arbiter.
// Revision : 1.0
// ============================================================================
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int LINE_BYTES = c_line_bytes_def
);
    logic                      rdy;
    logic                      rb;
    logic                      fc_valid;
    logic [c_addr_w-1:0]       fc_addr;
    logic                      fc_done;
    logic [8*LINE_BYTES-1:0]   fc_line;
    logic                      ld_valid;
    logic [c_addr_w-1:0]       ld_addr;
    logic [2:0]                ld_len;
    logic                      ld_done;
    logic [c_word_w-1:0]       ld_data;
    logic                      st_valid;
    logic [c_addr_w-1:0]       st_addr;
    logic [c_word_w-1:0]       st_data;
    logic [2:0]                st_len;
    logic                      st_done;
    logic                      io_buffer_full;
    logic                      ram_wr;
    logic [c_addr_w-1:0]       ram_addr;
    logic [7:0]                ram_dout;
    logic [7:0]                ram_din;

    modport slave (
        input  rdy, rb, fc_valid, fc_addr, ld_valid, ld_addr, ld_len,
               st_valid, st_addr, st_data, st_len, io_buffer_full, ram_din,
        output fc_done, fc_line, ld_done, ld_data, st_done,
               ram_wr, ram_addr, ram_dout
    );

    modport master (
        output rdy, rb, fc_valid, fc_addr, ld_valid, ld_addr, ld_len,
               st_valid, st_addr, st_data, st_len, io_buffer_full, ram_din,
        input  fc_done, fc_line, ld_done, ld_data, st_done,
               ram_wr, ram_addr, ram_dout
    );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter_byte_seq.sv
`default_nettype none
// ============================================================================
// Module   : mem_byte_seq
// Brief    : Byte address/counter engine with write shifter and read capture.
// Revision : 1.0
// ============================================================================
module mem_byte_seq
    import mem_arbiter_pkg::*;
#(
    parameter  int LINE_BYTES = c_line_bytes_def,
    localparam int CW         = $clog2(LINE_BYTES) + 1
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    input  wire logic                    i_rdy,
    input  wire logic                    i_start,
    input  wire logic [c_addr_w-1:0]     i_addr,
    input  wire logic [CW-1:0]           i_len,
    input  wire logic                    i_wr,
    input  wire logic [c_word_w-1:0]     i_wdata,
    input  wire logic                    i_step,
    input  wire logic                    i_abort,
    input  wire logic [7:0]              i_din,
    output logic [c_addr_w-1:0]          o_ram_addr,
    output logic                         o_ram_wr,
    output logic [7:0]                   o_ram_dout,
    output logic                         o_last,
    output logic [8*LINE_BYTES-1:0]      o_acc
);
    localparam int IW = $clog2(LINE_BYTES);

    logic [CW-1:0]             r_cnt;
    logic [CW-1:0]             r_len;
    logic                      r_wr;
    logic [c_addr_w-1:0]       r_addr;
    logic [7:0]                r_dout;
    logic [23:0]               r_wshift;
    logic [8*LINE_BYTES-1:0]   r_acc;
    logic                      r_rdy_q;
    logic [7:0]                r_din_hold;
    logic [7:0]                w_din;
    logic [IW-1:0]             w_idx;

    // The RAM keeps reading while stalled, so the byte due on the first stall
    // cycle is parked and replayed on the first cycle after rdy returns.
    assign w_din = r_rdy_q ? i_din : r_din_hold;
    assign w_idx = r_cnt[IW-1:0] - 1'b1;

    assign o_ram_addr = r_addr;
    assign o_ram_wr   = r_wr;
    assign o_ram_dout = r_dout;
    assign o_last     = r_wr ? (r_cnt == r_len - 1'b1) : (r_cnt == r_len);

    always_comb begin
        o_acc = r_acc;
        if (r_cnt != '0) begin
            o_acc[{w_idx, 3'b000} +: 8] = w_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_len      <= '0;
            r_wr       <= 1'b0;
            r_addr     <= '0;
            r_dout     <= '0;
            r_wshift   <= '0;
            r_acc      <= '0;
            r_rdy_q    <= 1'b1;
            r_din_hold <= '0;
        end else begin
            r_rdy_q <= i_rdy;
            if (!i_rdy && r_rdy_q) begin
                r_din_hold <= i_din;
            end
            if (i_rdy) begin
                if (i_start) begin
                    r_cnt    <= '0;
                    r_len    <= i_len;
                    r_wr     <= i_wr;
                    r_addr   <= i_addr;
                    r_dout   <= i_wdata[7:0];
                    r_wshift <= i_wdata[31:8];
                    r_acc    <= '0;
                end else if (i_abort || (i_step && o_last)) begin
                    r_cnt  <= '0;
                    r_wr   <= 1'b0;
                    r_addr <= '0;
                    r_dout <= '0;
                end else if (i_step) begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_wr) begin
                        r_addr   <= r_addr + 32'd1;
                        r_dout   <= r_wshift[7:0];
                        r_wshift <= {8'h00, r_wshift[23:8]};
                    end else begin
                        if (r_cnt + 1'b1 < r_len) begin
                            r_addr <= r_addr + 32'd1;
                        end
                        r_acc <= o_acc;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Fixed-priority (st > ld > fc) arbiter onto a byte-wide RAM port.
// Revision : 1.0
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int LINE_BYTES = c_line_bytes_def
) (
    input  wire logic      clk,
    input  wire logic      rst,
    mem_arbiter_if.slave   bus
);
    localparam int CW = $clog2(LINE_BYTES) + 1;

    state_t                    r_state;
    state_t                    w_next;
    logic                      r_io;
    logic                      r_fc_done;
    logic                      r_ld_done;
    logic                      r_st_done;
    logic [c_word_w-1:0]       r_ld_data;
    logic [8*LINE_BYTES-1:0]   r_fc_line;

    logic                      w_start;
    logic [c_addr_w-1:0]       w_addr;
    logic [CW-1:0]             w_len;
    logic                      w_wr;
    logic [c_word_w-1:0]       w_wdata;
    logic                      w_step;
    logic                      w_abort;
    logic                      w_done;
    logic                      w_last;
    logic                      w_seq_wr;
    logic                      w_io_block;
    logic                      w_st_req;
    logic                      w_ld_req;
    logic                      w_fc_req;
    logic [8*LINE_BYTES-1:0]   w_acc;

    // A requester still holds valid during its own done cycle; don't regrant it.
    assign w_st_req   = bus.st_valid & ~r_st_done;
    assign w_ld_req   = bus.ld_valid & ~r_ld_done & ~bus.rb;
    assign w_fc_req   = bus.fc_valid & ~r_fc_done & ~bus.rb;
    assign w_io_block = (r_state == S_STORE) & r_io & bus.io_buffer_full;

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_addr  = '0;
        w_len   = '0;
        w_wr    = 1'b0;
        w_wdata = '0;
        w_step  = 1'b0;
        w_abort = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_st_req) begin
                    w_next  = S_STORE;
                    w_start = 1'b1;
                    w_addr  = bus.st_addr;
                    w_len   = CW'(bus.st_len);
                    w_wr    = 1'b1;
                    w_wdata = bus.st_data;
                end else if (w_ld_req) begin
                    w_next  = S_LOAD;
                    w_start = 1'b1;
                    w_addr  = bus.ld_addr;
                    w_len   = CW'(bus.ld_len);
                end else if (w_fc_req) begin
                    w_next  = S_FETCH;
                    w_start = 1'b1;
                    w_addr  = bus.fc_addr;
                    w_len   = CW'(LINE_BYTES);
                end
            end
            S_FETCH, S_LOAD: begin
                if (bus.rb) begin
                    w_abort = 1'b1;
                    w_next  = S_IDLE;
                end else begin
                    w_step = 1'b1;
                    if (w_last) begin
                        w_done = 1'b1;
                        w_next = S_IDLE;
                    end
                end
            end
            S_STORE: begin
                // Committed stores ignore rollback; only a full UART stalls them.
                w_step = ~w_io_block;
                if (w_step && w_last) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_io      <= 1'b0;
            r_fc_done <= 1'b0;
            r_ld_done <= 1'b0;
            r_st_done <= 1'b0;
            r_ld_data <= '0;
            r_fc_line <= '0;
        end else if (bus.rdy) begin
            r_state   <= w_next;
            r_fc_done <= w_done && (r_state == S_FETCH);
            r_ld_done <= w_done && (r_state == S_LOAD);
            r_st_done <= w_done && (r_state == S_STORE);
            if (w_start) begin
                r_io <= (w_next == S_STORE) && (bus.st_addr[c_io_hi:c_io_lo] == c_io_sel);
            end
            if (w_done && (r_state == S_LOAD)) begin
                r_ld_data <= w_acc[c_word_w-1:0];
            end
            if (w_done && (r_state == S_FETCH)) begin
                r_fc_line <= w_acc;
            end
        end
    end

    mem_byte_seq #(
        .LINE_BYTES (LINE_BYTES)
    ) u_seq (
        .clk        (clk),
        .rst        (rst),
        .i_rdy      (bus.rdy),
        .i_start    (w_start),
        .i_addr     (w_addr),
        .i_len      (w_len),
        .i_wr       (w_wr),
        .i_wdata    (w_wdata),
        .i_step     (w_step),
        .i_abort    (w_abort),
        .i_din      (bus.ram_din),
        .o_ram_addr (bus.ram_addr),
        .o_ram_wr   (w_seq_wr),
        .o_ram_dout (bus.ram_dout),
        .o_last     (w_last),
        .o_acc      (w_acc)
    );

    assign bus.ram_wr  = w_seq_wr & ~w_io_block;
    assign bus.fc_done = r_fc_done;
    assign bus.ld_done = r_ld_done;
    assign bus.st_done = r_st_done;
    assign bus.ld_data = r_ld_data;
    assign bus.fc_line = r_fc_line;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed scoreboard bench for mem_arbiter with a synchronous RAM.
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;
    localparam int LB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [7:0]        mem [0:4095];
    logic [39:0]       exp_wr[$];
    int                exp_order[$];
    logic [31:0]       exp_ld[$];
    logic [8*LB-1:0]   exp_fc[$];

    mem_arbiter_if #(.LINE_BYTES(LB)) bus ();
    mem_arbiter #(.LINE_BYTES(LB)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Synchronous RAM: the byte addressed in one cycle appears on ram_din the next.
    always @(posedge clk) begin
        if (bus.ram_wr) mem[bus.ram_addr[11:0]] <= bus.ram_dout;
        bus.ram_din <= mem[bus.ram_addr[11:0]];
    end

    function automatic logic [7:0] rd(input logic [11:0] a);
        return mem[a];
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mon_done(input int ch);
        int o;
        if (exp_order.size() == 0) begin
            chk("done_unexpected", {bus.fc_done, bus.ld_done, bus.st_done}, 0);
        end else begin
            o = exp_order.pop_front();
            chk("done_order", ch, o);
            if (ch == 1 && exp_ld.size() != 0) chk("ld_data", bus.ld_data, exp_ld.pop_front());
            if (ch == 2 && exp_fc.size() != 0) chk("fc_line", bus.fc_line, exp_fc.pop_front());
        end
    endtask

    logic [39:0] mon_e;
    always @(negedge clk) begin
        if (!rst && bus.rdy) begin
            if (bus.ram_wr) begin
                if (bus.io_buffer_full && bus.ram_addr[17:16] == 2'b11)
                    chk("io_wr_while_full", bus.io_buffer_full, 0);
                if (exp_wr.size() == 0) begin
                    chk("ram_wr_unexpected", bus.ram_wr, 0);
                end else begin
                    mon_e = exp_wr.pop_front();
                    chk("ram_write", {bus.ram_addr, bus.ram_dout}, mon_e);
                end
            end
            if (bus.st_done) mon_done(0);
            if (bus.ld_done) mon_done(1);
            if (bus.fc_done) mon_done(2);
        end
    end

    task automatic issue_st(input logic [31:0] a, input logic [31:0] d, input int len);
        bus.st_addr = a; bus.st_data = d; bus.st_len = 3'(len); bus.st_valid = 1'b1;
        for (int k = 0; k < len; k++) exp_wr.push_back({a + k, d[8*k +: 8]});
        exp_order.push_back(0);
    endtask

    task automatic issue_ld(input logic [31:0] a, input int len, input logic [31:0] e, input bit push);
        bus.ld_addr = a; bus.ld_len = 3'(len); bus.ld_valid = 1'b1;
        if (push) begin
            exp_ld.push_back(e);
            exp_order.push_back(1);
        end
    endtask

    task automatic issue_fc(input logic [31:0] a, input bit push);
        logic [8*LB-1:0] line;
        bus.fc_addr = a; bus.fc_valid = 1'b1;
        if (push) begin
            for (int k = 0; k < LB; k++) line[8*k +: 8] = rd(a[11:0] + 12'(k));
            exp_fc.push_back(line);
            exp_order.push_back(2);
        end
    endtask

    task automatic wait_done(input int ch, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if ((ch == 0 && bus.st_done) || (ch == 1 && bus.ld_done) || (ch == 2 && bus.fc_done)) begin
                if (ch == 0) bus.st_valid = 1'b0;
                if (ch == 1) bus.ld_valid = 1'b0;
                if (ch == 2) bus.fc_valid = 1'b0;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL done_timeout channel=%0d actual=no_done required=done", ch);
        if (ch == 0) bus.st_valid = 1'b0;
        if (ch == 1) bus.ld_valid = 1'b0;
        if (ch == 2) bus.fc_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_fc_line", bus.fc_line, 0);
        chk("rst_ld_data", bus.ld_data, 0);
        chk("rst_ram_bus", {bus.ram_wr, bus.ram_addr, bus.ram_dout}, 0);
        chk("rst_dones", {bus.fc_done, bus.ld_done, bus.st_done}, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h3C;
        mem[12'h100] = 8'h11; mem[12'h101] = 8'h22; mem[12'h102] = 8'h33; mem[12'h103] = 8'h44;
        mem[12'h105] = 8'hF0; mem[12'h106] = 8'h9A; mem[12'h107] = 8'h78;
        bus.rdy = 1'b1; bus.rb = 1'b0; bus.io_buffer_full = 1'b0;
        bus.fc_valid = 1'b0; bus.fc_addr = '0;
        bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_len = '0;
        bus.st_valid = 1'b0; bus.st_addr = '0; bus.st_data = '0; bus.st_len = '0;
        repeat (3) @(posedge clk);
        #1 chk_reset_outputs();
        rst = 1'b0;

        // Word load: four consecutive read addresses, done five cycles after grant.
        @(posedge clk); #1 issue_ld(32'h100, 4, 32'h4433_2211, 1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1 chk("ld_addr_seq", bus.ram_addr, 32'h100 + k);
        end
        @(posedge clk); #1 chk("ld_done_early", bus.ld_done, 0);
        @(posedge clk); #1 chk("ld_done_latency", bus.ld_done, 1);
        bus.ld_valid = 1'b0;

        // Byte and halfword loads are zero-extended.
        @(posedge clk); #1 issue_ld(32'h105, 1, 32'h0000_00F0, 1);
        wait_done(1, 20);
        @(posedge clk); #1 issue_ld(32'h106, 2, 32'h0000_789A, 1);
        wait_done(1, 20);

        // Halfword store, little-endian, done in the cycle after the last byte.
        @(posedge clk); #1 issue_st(32'h200, 32'h0000_ABCD, 2);
        @(posedge clk); #1 chk("st_byte0", {bus.ram_wr, bus.ram_addr, bus.ram_dout}, {1'b1, 32'h200, 8'hCD});
        @(posedge clk); #1 chk("st_byte1", {bus.ram_wr, bus.ram_addr, bus.ram_dout}, {1'b1, 32'h201, 8'hAB});
        @(posedge clk); #1 chk("st_done", {bus.st_done, bus.ram_wr}, 2'b10);
        bus.st_valid = 1'b0;

        // Simultaneous requests are served st, ld, fc.
        @(posedge clk); #1;
        issue_st(32'h210, 32'h0000_0077, 1);
        issue_ld(32'h100, 4, 32'h4433_2211, 1);
        issue_fc(32'h400, 1);
        fork
            wait_done(0, 80);
            wait_done(1, 80);
            wait_done(2, 80);
        join

        // Rollback while byte 7 of a fetch is addressed.
        @(posedge clk); #1 issue_fc(32'h480, 0);
        for (int k = 0; k < 8; k++) @(posedge clk);
        #1 chk("fc_byte7_addr", bus.ram_addr, 32'h487);
        bus.rb = 1'b1;
        @(posedge clk); #1;
        bus.rb = 1'b0; bus.fc_valid = 1'b0;
        chk("rb_idle_addr", bus.ram_addr, 0);
        chk("rb_no_fc_done", bus.fc_done, 0);
        issue_ld(32'h105, 1, 32'h0000_00F0, 1);
        wait_done(1, 20);

        // Rollback coinciding with the completing cycle of a byte load.
        @(posedge clk); #1 issue_ld(32'h100, 1, 32'h0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1 bus.rb = 1'b1;
        @(posedge clk); #1;
        bus.rb = 1'b0; bus.ld_valid = 1'b0;
        chk("rb_ld_done_suppressed", bus.ld_done, 0);

        // Rollback during a store does not stop it.
        @(posedge clk); #1 issue_st(32'h220, 32'h1357_2468, 4);
        @(posedge clk); #1;
        @(posedge clk); #1 bus.rb = 1'b1;
        @(posedge clk); #1 bus.rb = 1'b0;
        wait_done(0, 20);

        // UART store held off by a full buffer for three cycles.
        @(posedge clk); #1;
        bus.io_buffer_full = 1'b1;
        issue_st(32'h0003_0000, 32'h0000_0041, 1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1 chk("io_wr_held", bus.ram_wr, 0);
        end
        @(posedge clk); #1 bus.io_buffer_full = 1'b0;
        wait_done(0, 20);

        // Two-cycle rdy stall in the middle of a word load.
        @(posedge clk); #1 issue_ld(32'h100, 4, 32'h4433_2211, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1 bus.rdy = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 bus.rdy = 1'b1;
        wait_done(1, 20);

        // Reset in the middle of a fetch.
        @(posedge clk); #1 issue_fc(32'h500, 0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        bus.fc_valid = 1'b0;
        chk_reset_outputs();
        @(posedge clk); #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1 chk("post_rst_idle_addr", bus.ram_addr, 0);
        chk("scoreboard_drained", exp_order.size() + exp_wr.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
